gemm_sched: RTL

- Issue scheduler for the 4-point complex GEMM/butterfly pipeline. It shares one GEMM instance between two requesters, for example two FFT stages.
- Arbitrates round-robin between the two requesters and drives the GEMM inputs and start pulse.
- Switches the size2/size4 control only when the pipeline is drained.
- Tracks in-flight beats with a tag pipeline and returns results through a credit-protected response FIFO with valid/ready.

---
 rtl/gemm_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gemm_sched.sv
// Issue scheduler sharing one GEMM between two requesters: round-robin grant,
// drain-then-switch of the size2/size4 mode, tag pipeline and credited response FIFO.
module gemm_sched #(
    parameter int SFP_W     = 9,
    parameter int GEMM_LAT  = 4,
    parameter int RSP_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic                 req0_size4_i,
    input  logic [4*SFP_W-1:0]   req0_dr_i,
    input  logic [4*SFP_W-1:0]   req0_di_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic                 req1_size4_i,
    input  logic [4*SFP_W-1:0]   req1_dr_i,
    input  logic [4*SFP_W-1:0]   req1_di_i,
    output logic                 gemm_start_o,
    output logic                 gemm_control_o,
    output logic [4*SFP_W-1:0]   gemm_dr_o,
    output logic [4*SFP_W-1:0]   gemm_di_o,
    input  logic [4*SFP_W-1:0]   gemm_dr_i,
    input  logic [4*SFP_W-1:0]   gemm_di_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_id_o,
    output logic [4*SFP_W-1:0]   rsp_dr_o,
    output logic [4*SFP_W-1:0]   rsp_di_o,
    output logic                 busy_o
);
    localparam int DW    = 4*SFP_W;
    localparam int TAG_N = GEMM_LAT + 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int AW    = $clog2(RSP_DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(RSP_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(RSP_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH} state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              mode_q, mode_d;
    logic              pend_q, pend_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TAG_N-1:0]  tag_v_q, tag_id_q;
    logic              start_q;
    logic [DW-1:0]     op_dr_q, op_di_q;
    logic [AW-1:0]     wr_q, rd_q;
    logic [DW-1:0]     fifo_dr_q [RSP_DEPTH];
    logic [DW-1:0]     fifo_di_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_id_q;

    logic        any_v, cand, cand_size, issue_ok, grant;
    logic        push, pop;
    logic [CW:0] credit_used;

    assign any_v       = req0_valid_i | req1_valid_i;
    assign cand        = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
    assign cand_size   = cand ? req1_size4_i : req0_size4_i;
    // Credit uses start-of-cycle values; a same-cycle pop frees a slot only next cycle.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_ok    = credit_used < DEPTH_W;
    assign push        = tag_v_q[TAG_N-1];
    assign pop         = rsp_valid_o && rsp_ready_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        grant   = 1'b0;
        case (state_q)
            S_RUN: begin
                if (any_v && !rst_i) begin
                    if (cand_size != mode_q) begin
                        pend_d  = cand_size;
                        state_d = S_DRAIN;
                    end else if (issue_ok) begin
                        grant = 1'b1;
                        if (cand == ptr_q) ptr_d = ~ptr_q;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) state_d = S_SWITCH;
            end
            S_SWITCH: begin
                mode_d  = pend_q;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (grant && !push) inflight_d = inflight_q + CW'(1);
        else if (!grant && push) inflight_d = inflight_q - CW'(1);
        count_d = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_RUN;
            ptr_q      <= 1'b0;
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            inflight_q <= '0;
            count_q    <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            start_q    <= 1'b0;
            op_dr_q    <= '0;
            op_di_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            assert (!(push && count_q == FULL_C && !pop));
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            tag_v_q    <= {tag_v_q[TAG_N-2:0], grant};
            tag_id_q   <= {tag_id_q[TAG_N-2:0], cand};
            start_q    <= grant;
            if (grant) begin
                op_dr_q <= cand ? req1_dr_i : req0_dr_i;
                op_di_q <= cand ? req1_di_i : req0_di_i;
            end
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_dr_q[wr_q] <= gemm_dr_i;
            fifo_di_q[wr_q] <= gemm_di_i;
            fifo_id_q[wr_q] <= tag_id_q[TAG_N-1];
        end
    end

    assign req0_ready_o   = grant && !cand;
    assign req1_ready_o   = grant && cand;
    assign gemm_start_o   = start_q;
    assign gemm_control_o = mode_q;
    assign gemm_dr_o      = op_dr_q;
    assign gemm_di_o      = op_di_q;
    assign rsp_valid_o    = count_q != '0;
    assign rsp_id_o       = fifo_id_q[rd_q];
    assign rsp_dr_o       = fifo_dr_q[rd_q];
    assign rsp_di_o       = fifo_di_q[rd_q];
    assign busy_o         = (inflight_q != '0) || (count_q != '0);
endmodule
